// File: rtl/int_wb_arbiter.sv
// int_wb_arbiter: round-robin share of the integer register file write port, with a pending-write scoreboard
module int_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  localparam int GW = (NUM_REQ > 2) ? 2 : 1,
  localparam int NREG = 2 ** ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_addr,
  output logic [NREG-1:0]           pending,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_data,
  output logic [GW-1:0]             grant_id
);
  logic [GW-1:0] rr_q, rr_d, gid_q, gid_d, win_id;
  logic [ADDR_W-1:0] wa_q, wa_d, win_addr;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [NREG-1:0] pend_q, pend_d, set_v, clr_v;
  logic we_q, we_d, any, hs;
  always_comb begin
    win_id = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        win_id = GW'((int'(rr_q) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
    hs = reset && any;
    req_ready = hs ? NUM_REQ'(1) << win_id : '0;
    win_addr = req_addr[win_id*ADDR_W +: ADDR_W];
    rr_d = hs ? ((win_id == GW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1) : rr_q;
    we_d = hs && (win_addr != '0);
    wa_d = hs ? win_addr : wa_q;
    wd_d = hs ? req_data[win_id*DATA_W +: DATA_W] : wd_q;
    gid_d = hs ? win_id : gid_q;
    set_v = alloc_valid ? NREG'(1) << alloc_addr : '0;
    clr_v = we_q ? NREG'(1) << wa_q : '0;
    pend_d = (set_v | (pend_q & ~clr_v)) & ~NREG'(1);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_q <= '0;
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      gid_q <= '0;
      pend_q <= '0;
    end else begin
      rr_q <= rr_d;
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      gid_q <= gid_d;
      pend_q <= pend_d;
    end
  end
  assign write_enable = we_q;
  assign write_addr = wa_q;
  assign write_data = wd_q;
  assign grant_id = gid_q;
  assign pending = pend_q;
endmodule

// File: tb/tb_int_wb_arbiter.sv
// tb_int_wb_arbiter: directed and random stimulus against a queue-based reference model with a decoupled write monitor
module tb_int_wb_arbiter;
  localparam int N = 3;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int GW = 2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic alloc_valid = 1'b0;
  logic [AW-1:0] alloc_addr = '0;
  logic [NR-1:0] pending;
  logic write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [GW-1:0] grant_id;
  always #5 clock = ~clock;
  int_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .pending(pending), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data), .grant_id(grant_id)
  );
  typedef struct {
    int cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int id;
  } wr_t;
  wr_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [NR-1:0] exp_pend = '0;
  int m_rr = 0;
  logic m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic va[N];
  logic [AW-1:0] ra[N];
  logic [DW-1:0] rd[N];
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    va[i] = v;
    ra[i] = a;
    rd[i] = d;
  endtask
  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
  endtask
  task automatic step(input logic rst, input logic av, input logic [AW-1:0] aa);
    int win;
    logic [NR-1:0] p;
    @(negedge clock);
    reset = rst;
    alloc_valid = av;
    alloc_addr = aa;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = va[i];
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
    #1;
    win = -1;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        if (va[(m_rr + k) % N]) begin
          win = (m_rr + k) % N;
          break;
        end
      end
    end
    chk("req_ready", 64'(req_ready), (win < 0) ? 64'd0 : 64'd1 << win);
    p = exp_pend;
    if (m_we) p[m_wa] = 1'b0;
    if (av && aa != '0) p[aa] = 1'b1;
    exp_pend = rst ? p : '0;
    if (!rst) begin
      m_rr = 0;
      m_we = 1'b0;
    end else if (win >= 0) begin
      m_rr = (win + 1) % N;
      m_we = ra[win] != '0;
      m_wa = ra[win];
      if (m_we) exp_q.push_back('{cyc + 1, ra[win], rd[win], win});
      va[win] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
  endtask
  initial begin
    wr_t e;
    forever begin
      @(posedge clock);
      #1;
      chk("pending", 64'(pending), 64'(exp_pend));
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write (cycle %0d): got addr %0h data %0h, required no write", cyc, write_addr, write_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
          chk("write_addr", 64'(write_addr), 64'(e.a));
          chk("write_data", write_data, e.d);
          chk("grant_id", 64'(grant_id), 64'(e.id));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_write (cycle %0d): got write_enable 0, required write to %0h", cyc, exp_q[0].a);
        void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 4), DW'(i));
    step(1'b0, 1'b1, 5'd7);
    step(1'b0, 1'b1, 5'd7);
    clear_reqs();
    step(1'b1, 1'b0, '0);
    set_req(1, 1'b1, 5'd5, 64'hDEAD);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), {$urandom, $urandom});
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < N; i++) if (!va[i]) set_req(i, 1'b1, AW'(i + 1), {$urandom, $urandom});
    end
    clear_reqs();
    set_req(0, 1'b1, 5'd0, 64'hFF);
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 10), DW'(i + 100));
    step(1'b1, 1'b0, '0);
    clear_reqs();
    step(1'b1, 1'b0, '0);
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 1'b1, 5'd7);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      set_req(2, 1'b1, 5'd7, 64'h1234_0000 + 64'(r));
      step(1'b1, 1'b0, '0);
      step(1'b1, r == 1, 5'd7);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
    end
    set_req(0, 1'b1, 5'd9, 64'h9999);
    step(1'b1, 1'b1, 5'd12);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 20), DW'(i + 200));
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!va[i] && $urandom_range(1, 0) == 1) set_req(i, 1'b1, AW'($urandom_range(31, 0)), {$urandom, $urandom});
      step($urandom_range(49, 0) != 0, $urandom_range(1, 0) == 1, AW'($urandom_range(31, 0)));
    end
    clear_reqs();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
